reg_mem_bist_ctrl: RTL and testbench
====================================

// Module: reg_mem_bist_ctrl
// PURPOSE
// - Upstream sequencer for reg_mem. Drives its addr/data_in/wen and consumes data_out.
// - On start: writes a count-word incrementing pattern from base_addr, reads it back, compares each word.
// - Reports pass/fail, mismatch count and first failing address. Used as power-up self-test of the register memory.
// PARAMETERS
// - DATA_WIDTH  8  word width; must match reg_mem
// - ADDR_BITS   5  address width; depth = 2**ADDR_BITS; must match reg_mem
// - RD_LAT      0  reg_mem read latency in cycles; legal 0 (combinational) or 1 (registered)
// PORTS
// - clk           in   1              rising-edge clock
// - rst_n         in   1              asynchronous active-low reset
// - start         in   1              pulse; begins a test when idle
// - base_addr     in   ADDR_BITS      first address tested
// - count         in   ADDR_BITS+1    words to test, 0..2**ADDR_BITS
// - seed          in   DATA_WIDTH     pattern value written to base_addr
// - busy          out  1              test in progress
// - done          out  1              test finished; sticky until next accepted start
// - pass          out  1              valid while done; 1 = no mismatches
// - err_count     out  ADDR_BITS+1    mismatches, saturating at all-ones
// - fail_addr     out  ADDR_BITS      address of first mismatch; 0 if none
// - mem_addr      out  ADDR_BITS      to reg_mem addr
// - mem_data_in   out  DATA_WIDTH     to reg_mem data_in
// - mem_wen       out  1              to reg_mem wen
// - mem_data_out  in   DATA_WIDTH     from reg_mem data_out
// BEHAVIOUR
// - Reset, asynchronous on rst_n low: state=IDLE; every output 0, including mem_wen.
//   - Reset mid-test aborts immediately. No partial result kept.
// - FSM states: IDLE -> WRITE -> READ -> DRAIN (RD_LAT=1 only) -> DONE. DONE -> WRITE on start.
// - Start acceptance:
//   - start is sampled in IDLE or DONE.
//   - On acceptance: done, pass, err_count and fail_addr clear; busy=1 from the next cycle.
//   - start while busy is ignored.
// - count=0: go straight to DONE. busy is high 1 cycle; done=1, pass=1; no memory access.
// - WRITE, cycle i = 0..count-1, one word per cycle:
//   - mem_wen=1
//   - mem_addr = base_addr+i, mod 2**ADDR_BITS; wraps past top of memory
//   - mem_data_in = seed+i, mod 2**DATA_WIDTH
// - READ, cycles i = 0..count-1:
//   - mem_wen=0; same mem_addr sequence as WRITE.
//   - Expected word = seed+i. It is compared against mem_data_out RD_LAT cycles after the address is presented.
// - DRAIN: one cycle for the final compare when RD_LAT=1.
// - Mismatch handling:
//   - err_count increments and saturates.
//   - The first mismatch latches fail_addr, the address that produced the bad word.
// - busy stays high exactly 2*count+RD_LAT cycles (+2*count extra with the option below).
//   - On the edge where busy falls: done=1, pass=(err_count==0).
// - mem_data_in holds its last value outside WRITE. mem_addr holds its last value outside WRITE/READ.
// - base_addr, count and seed are captured at start acceptance. Later changes have no effect.
// CONFIGURATION
// - REG_MEM_BIST_INV_PASS_EN defined:
//   - After READ/DRAIN, a second WRITE+READ runs over the same addresses with pattern ~(seed+i).
//   - Compare, err_count and fail_addr rules are identical and accumulate across both passes.
//   - Ends with memory holding the inverted pattern.
// - Not defined: single pass only; memory ends holding seed+i.
// TESTING
// - Reset then idle: all outputs 0, mem_wen=0, busy=0.
// - base=3, count=29, seed=1: writes 1..29 to addr 3..31; busy 58 cycles (RD_LAT=0); done=1, pass=1, err_count=0.
// - Wrap-around: base=30, count=4, seed=8'hFE.
//   - Writes FE,FF,00,01 to addr 30,31,0,1.
//   - pass=1.
// - Fault injection: bench model forces data_out^=1 at addr 5 and 9; base=0, count=16.
//   - pass=0, err_count=2, fail_addr=5.
// - count=0 -> done after 1 busy cycle, pass=1, mem_wen never high.
// - Robustness: start pulsed mid-test is ignored. rst_n low mid-READ -> busy=0, mem_wen=0 asynchronously.
//   - Restart then completes with pass=1.
// - Option and latency coverage: rerun all with RD_LAT=1 and with REG_MEM_BIST_INV_PASS_EN.
//   - With the macro, count=4 holds busy 16 cycles.

Source files
------------

// File: rtl/reg_mem_bist_ctrl.sv
// Power-up self-test sequencer for reg_mem: writes an incrementing pattern, reads it back and compares each word.
// Optional macro REG_MEM_BIST_INV_PASS_EN adds a second write/read pass with the inverted pattern.
module reg_mem_bist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int RD_LAT     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [ADDR_BITS:0]    count,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_BITS:0]    err_count,
  output logic [ADDR_BITS-1:0]  fail_addr,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int CW = ADDR_BITS + 1;
  localparam logic [ADDR_BITS-1:0]  ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]         CNT_MAX  = {CW{1'b1}};
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam bit REG_RD = (RD_LAT == 32'sd1);
`ifdef REG_MEM_BIST_INV_PASS_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic                    phase_r, phase_s;
  logic [ADDR_BITS-1:0]    base_r, base_s;
  logic [CW-1:0]           count_r, count_s;
  logic [DATA_WIDTH-1:0]   seed_r, seed_s;
  logic [CW-1:0]           idx_r, idx_s;
  logic [DATA_WIDTH-1:0]   pat_r, pat_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    pass_r, pass_s;
  logic [CW-1:0]           err_r, err_s;
  logic [ADDR_BITS-1:0]    fail_r, fail_s;
  logic [ADDR_BITS-1:0]    addr_r, addr_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
  logic                    wen_r, wen_s;
  logic                    cmp_vld_r, cmp_vld_s;
  logic [DATA_WIDTH-1:0]   cmp_exp_r, cmp_exp_s;
  logic [ADDR_BITS-1:0]    cmp_addr_r, cmp_addr_s;
  logic                    last_s;
  logic [DATA_WIDTH-1:0]   rd_exp_s;
  logic [DATA_WIDTH-1:0]   pat_inc_s;
  logic                    chk_vld_s;
  logic [DATA_WIDTH-1:0]   chk_exp_s;
  logic [ADDR_BITS-1:0]    chk_addr_s;

  // Next-state, compare and output computation for the whole sequencer.
  always_comb begin
    state_s    = state_r;
    phase_s    = phase_r;
    base_s     = base_r;
    count_s    = count_r;
    seed_s     = seed_r;
    idx_s      = idx_r;
    pat_s      = pat_r;
    busy_s     = busy_r;
    done_s     = done_r;
    pass_s     = pass_r;
    err_s      = err_r;
    fail_s     = fail_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    wen_s      = wen_r;
    last_s     = (idx_r == (count_r - CNT_ONE));
    rd_exp_s   = phase_r ? ~pat_r : pat_r;
    pat_inc_s  = pat_r + DATA_ONE;
    cmp_vld_s  = (state_r == ST_READ);
    cmp_exp_s  = rd_exp_s;
    cmp_addr_s = addr_r;

    // With a registered memory the word for a READ address is judged one cycle later.
    if (REG_RD) begin
      chk_vld_s  = cmp_vld_r;
      chk_exp_s  = cmp_exp_r;
      chk_addr_s = cmp_addr_r;
    end else begin
      chk_vld_s  = (state_r == ST_READ);
      chk_exp_s  = rd_exp_s;
      chk_addr_s = addr_r;
    end

    if (chk_vld_s && (mem_data_out != chk_exp_s)) begin
      if (err_r != CNT_MAX) begin
        err_s = err_r + CNT_ONE;
      end else begin
        err_s = err_r;
      end
      if (err_r == CNT_ZERO) begin
        fail_s = chk_addr_s;
      end else begin
        fail_s = fail_r;
      end
    end else begin
      err_s  = err_r;
      fail_s = fail_r;
    end

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          base_s  = base_addr;
          count_s = count;
          seed_s  = seed;
          phase_s = 1'b0;
          idx_s   = CNT_ZERO;
          pat_s   = seed;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          pass_s  = 1'b0;
          err_s   = CNT_ZERO;
          fail_s  = {ADDR_BITS{1'b0}};
          // An empty test still spends its single busy cycle in DRAIN, with nothing to compare.
          if (count == CNT_ZERO) begin
            state_s = ST_DRAIN;
            wen_s   = 1'b0;
          end else begin
            state_s = ST_WRITE;
            wen_s   = 1'b1;
            addr_s  = base_addr;
            wdata_s = seed;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_WRITE: begin
        if (last_s) begin
          state_s = ST_READ;
          wen_s   = 1'b0;
          addr_s  = base_r;
          idx_s   = CNT_ZERO;
          pat_s   = seed_r;
        end else begin
          idx_s   = idx_r + CNT_ONE;
          pat_s   = pat_inc_s;
          addr_s  = addr_r + ADDR_ONE;
          wdata_s = phase_r ? ~pat_inc_s : pat_inc_s;
        end
      end
      ST_READ: begin
        if (last_s) begin
          if (INV_EN && !phase_r) begin
            state_s = ST_WRITE;
            phase_s = 1'b1;
            wen_s   = 1'b1;
            addr_s  = base_r;
            wdata_s = ~seed_r;
            idx_s   = CNT_ZERO;
            pat_s   = seed_r;
          end else if (REG_RD) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (err_s == CNT_ZERO);
          end
        end else begin
          idx_s  = idx_r + CNT_ONE;
          pat_s  = pat_inc_s;
          addr_s = addr_r + ADDR_ONE;
        end
      end
      ST_DRAIN: begin
        state_s = ST_DONE;
        busy_s  = 1'b0;
        done_s  = 1'b1;
        pass_s  = (err_s == CNT_ZERO);
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        wen_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any test in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      phase_r    <= 1'b0;
      base_r     <= {ADDR_BITS{1'b0}};
      count_r    <= CNT_ZERO;
      seed_r     <= {DATA_WIDTH{1'b0}};
      idx_r      <= CNT_ZERO;
      pat_r      <= {DATA_WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      err_r      <= CNT_ZERO;
      fail_r     <= {ADDR_BITS{1'b0}};
      addr_r     <= {ADDR_BITS{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      wen_r      <= 1'b0;
      cmp_vld_r  <= 1'b0;
      cmp_exp_r  <= {DATA_WIDTH{1'b0}};
      cmp_addr_r <= {ADDR_BITS{1'b0}};
    end else begin
      state_r    <= state_s;
      phase_r    <= phase_s;
      base_r     <= base_s;
      count_r    <= count_s;
      seed_r     <= seed_s;
      idx_r      <= idx_s;
      pat_r      <= pat_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      pass_r     <= pass_s;
      err_r      <= err_s;
      fail_r     <= fail_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      wen_r      <= wen_s;
      cmp_vld_r  <= cmp_vld_s;
      cmp_exp_r  <= cmp_exp_s;
      cmp_addr_r <= cmp_addr_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign err_count   = err_r;
  assign fail_addr   = fail_r;
  assign mem_addr    = addr_r;
  assign mem_data_in = wdata_r;
  assign mem_wen     = wen_r;

endmodule

// File: tb/tb_reg_mem_bist_ctrl.sv
// Self-checking bench for reg_mem_bist_ctrl with a behavioural reg_mem model and fault injection.
module tb_reg_mem_bist_ctrl;
  parameter int RD_LAT = 0;
`ifdef REG_MEM_BIST_INV_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic       pass;
    logic [5:0] err;
    logic [4:0] fail;
    int         busy;
  } res_t;

  logic       clk, rst_n, start;
  logic [4:0] base_addr;
  logic [5:0] count;
  logic [7:0] seed;
  logic       busy, done, pass;
  logic [5:0] err_count;
  logic [4:0] fail_addr, mem_addr;
  logic [7:0] mem_data_in, mem_data_out;
  logic       mem_wen;

  logic [7:0] mem_model [0:31];
  logic [7:0] rd_q;
  logic [7:0] fault_mask;
  logic       fault_en;
  wr_t        wq[$];
  res_t       rq[$];
  int         checks, errors, busy_cnt;
  bit         wen_seen;

  reg_mem_bist_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(5), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_addr(fail_addr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wen(mem_wen), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational or registered read, stuck bit 0 at addr 5 and 9 when faulted.
  assign fault_mask = (fault_en && (mem_addr == 5'd5 || mem_addr == 5'd9)) ? 8'h01 : 8'h00;
  always @(posedge clk) begin
    if (mem_wen) mem_model[mem_addr] <= mem_data_in;
    rd_q <= mem_model[mem_addr] ^ fault_mask;
  end
  always_comb begin
    if (RD_LAT == 0) mem_data_out = mem_model[mem_addr] ^ fault_mask;
    else mem_data_out = rd_q;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and busy-cycle counter, sampled on the falling edge.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (mem_wen) begin
      wen_seen = 1'b1;
      if (wq.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        check("write_addr", 32'(mem_addr), 32'(w.a));
        check("write_data", 32'(mem_data_in), 32'(w.d));
      end
    end
  end

  task automatic run_test(input logic [4:0] b, input logic [5:0] c, input logic [7:0] s, input bit mid);
    res_t r;
    int   e_err;
    logic [4:0] e_fail;
    e_err  = 0;
    e_fail = 5'd0;
    for (int p = 0; p < PASSES; p++) begin
      for (int i = 0; i < int'(c); i++) begin
        wr_t w;
        w.a = 5'((int'(b) + i) % 32);
        w.d = 8'(int'(s) + i);
        if (p == 1) w.d = ~w.d;
        wq.push_back(w);
        if (fault_en && (w.a == 5'd5 || w.a == 5'd9)) begin
          if (e_err == 0) e_fail = w.a;
          if (e_err < 63) e_err++;
        end
      end
    end
    r.pass = (e_err == 0);
    r.err  = 6'(e_err);
    r.fail = e_fail;
    r.busy = (c == 6'd0) ? 1 : PASSES * 2 * int'(c) + RD_LAT;
    rq.push_back(r);
    busy_cnt = 0;
    @(negedge clk);
    base_addr = b; count = c; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = ~b; seed = ~s; count = 6'd5;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done_clr", 32'(done), 32'd0);
    check("accept_err_clr", 32'(err_count), 32'd0);
    for (int k = 0; k < 600 && !done; k++) begin
      start = mid && (k == 2);
      if (mid && k == 2) begin
        base_addr = 5'd20; count = 6'd3;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    r = rq.pop_front();
    check("pass", 32'(pass), 32'(r.pass));
    check("err_count", 32'(err_count), 32'(r.err));
    check("fail_addr", 32'(fail_addr), 32'(r.fail));
    check("busy_cycles", 32'(busy_cnt), 32'(r.busy));
    check("busy_low", 32'(busy), 32'd0);
    check("writes_left", 32'(wq.size()), 32'd0);
    wq.delete();
    repeat (3) @(negedge clk);
    check("done_sticky", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; busy_cnt = 0; wen_seen = 1'b0; fault_en = 1'b0;
    rst_n = 1'b0; start = 1'b0; base_addr = 5'd0; count = 6'd0; seed = 8'd0;
    for (int i = 0; i < 32; i++) mem_model[i] = 8'h00;
    rd_q = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_fail", 32'(fail_addr), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_data_in), 32'd0);
    check("rst_wen", 32'(mem_wen), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_wen", 32'(mem_wen), 32'd0);

    run_test(5'd3, 6'd29, 8'h01, 1'b0);

    run_test(5'd30, 6'd4, 8'hFE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ev;
      ev = 8'(8'hFE + i);
      if (PASSES == 2) ev = ~ev;
      check("wrap_mem", 32'(mem_model[(30 + i) % 32]), 32'(ev));
    end

    fault_en = 1'b1;
    run_test(5'd0, 6'd16, 8'h10, 1'b0);
    fault_en = 1'b0;

    wen_seen = 1'b0;
    run_test(5'd12, 6'd0, 8'h55, 1'b0);
    check("zero_no_wen", 32'(wen_seen), 32'd0);

    run_test(5'd0, 6'd8, 8'h40, 1'b1);

    // Reset in the middle of READ, then a clean restart.
    for (int i = 0; i < 16; i++) begin
      wr_t w;
      w.a = 5'(i);
      w.d = 8'(8'h33 + i);
      wq.push_back(w);
    end
    @(negedge clk);
    base_addr = 5'd0; count = 6'd16; seed = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_wen", 32'(mem_wen), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_wen", 32'(mem_wen), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    wq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_test(5'd7, 6'd12, 8'hA0, 1'b0);

    run_test(5'd17, 6'd32, 8'hF0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
